// File: rtl/conv_mac_pipe.sv
// Pipelined signed window-by-kernel MAC with valid/ready flow control, arithmetic
// right-shift normalisation, optional ReLU, saturation to BITS and a sticky saturation counter.
module conv_mac_pipe #(
    parameter int BITS        = 9,
    parameter int KERNEL_SIZE = 3,
    parameter int SHIFT_W     = 4,
    parameter int CNT_W       = 16
) (
    input  logic                                    clk,
    input  logic                                    reset,
    input  logic                                    in_valid,
    output logic                                    in_ready,
    input  logic [KERNEL_SIZE*KERNEL_SIZE*BITS-1:0] window_in,
    input  logic [KERNEL_SIZE*KERNEL_SIZE*BITS-1:0] kernel_in,
    input  logic [SHIFT_W-1:0]                      shift_amt,
    input  logic                                    relu_en,
    output logic                                    out_valid,
    input  logic                                    out_ready,
    output logic [BITS-1:0]                         pixel_out,
    output logic                                    sat_out,
    output logic [CNT_W-1:0]                        sat_count,
    input  logic                                    sat_count_clr
);

    localparam int N  = KERNEL_SIZE * KERNEL_SIZE;
    localparam int PW = 2 * BITS;
    localparam int SW = PW + $clog2(N);
    localparam int MAX_I = 2 ** (BITS - 1) - 1;
    localparam int MIN_I = -(2 ** (BITS - 1));
    localparam logic signed [SW-1:0] SAT_HI = SW'(MAX_I);
    localparam logic signed [SW-1:0] SAT_LO = SW'(MIN_I);

    logic                   advance;
    logic signed [PW-1:0]   prod_q [N];
    logic [SHIFT_W-1:0]     shift_q1;
    logic                   relu_q1;
    logic                   v1;
    logic signed [SW-1:0]   sum_c;
    logic signed [SW-1:0]   sum_q;
    logic [SHIFT_W-1:0]     shift_q2;
    logic                   relu_q2;
    logic                   v2;
    logic signed [SW-1:0]   sh_c;
    logic [BITS-1:0]        pix_c;
    logic                   sat_c;

    // Every stage holds whenever the output register is full and not being taken.
    assign advance  = !out_valid || out_ready;
    assign in_ready = advance;

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            v1       <= 1'b0;
            shift_q1 <= '0;
            relu_q1  <= 1'b0;
            for (int i = 0; i < N; i++) prod_q[i] <= '0;
        end else if (advance) begin
            v1       <= in_valid;
            shift_q1 <= shift_amt;
            relu_q1  <= relu_en;
            for (int i = 0; i < N; i++)
                prod_q[i] <= $signed(window_in[i*BITS +: BITS]) * $signed(kernel_in[i*BITS +: BITS]);
        end
    end

    always_comb begin
        sum_c = '0;
        for (int i = 0; i < N; i++)
            sum_c = sum_c + {{(SW-PW){prod_q[i][PW-1]}}, prod_q[i]};
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            v2       <= 1'b0;
            sum_q    <= '0;
            shift_q2 <= '0;
            relu_q2  <= 1'b0;
        end else if (advance) begin
            v2       <= v1;
            sum_q    <= sum_c;
            shift_q2 <= shift_q1;
            relu_q2  <= relu_q1;
        end
    end

    // ReLU is applied before clipping, so a ReLU-zeroed result never reports saturation.
    always_comb begin
        sh_c = sum_q >>> shift_q2;
        if (relu_q2 && sh_c < 0)
            sh_c = '0;
        sat_c = 1'b0;
        pix_c = sh_c[BITS-1:0];
        if (sh_c > SAT_HI) begin
            pix_c = SAT_HI[BITS-1:0];
            sat_c = 1'b1;
        end else if (sh_c < SAT_LO) begin
            pix_c = SAT_LO[BITS-1:0];
            sat_c = 1'b1;
        end
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            out_valid <= 1'b0;
            pixel_out <= '0;
            sat_out   <= 1'b0;
        end else if (advance) begin
            out_valid <= v2;
            pixel_out <= pix_c;
            sat_out   <= sat_c;
        end
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset)
            sat_count <= '0;
        else if (sat_count_clr)
            sat_count <= '0;
        else if (out_valid && out_ready && sat_out && sat_count != '1)
            sat_count <= sat_count + 1'b1;
    end

endmodule
